// File: rtl/divisor_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// divisor_pkg : shared state encoding and board timebase defaults
// Rev 1.0
// ----------------------------------------------------------------------------
package divisor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int BOARD_DEFAULT_DIV = 2500000;
    localparam int BOARD_MIN_DIV     = 1;

endpackage
`default_nettype wire

// File: rtl/divisor_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// divisor_core : half-period counter with terminal compare, s_clk and tick
// Rev 1.0
// ----------------------------------------------------------------------------
module divisor_core
    import divisor_pkg::*;
#(
    parameter int WIDTH = 22
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             count_en,
    input  logic             clear,
    input  logic [WIDTH-1:0] term,
    output logic             tc,
    output logic             s_clk,
    output logic             tick
);

    logic [WIDTH-1:0] cuenta;

    assign tc = (cuenta == term);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cuenta <= '0;
            s_clk  <= 1'b0;
            tick   <= 1'b0;
        end else if (clear) begin
            cuenta <= '0;
            s_clk  <= 1'b0;
            tick   <= 1'b0;
        end else if (count_en) begin
            if (tc) begin
                cuenta <= '0;
                s_clk  <= ~s_clk;
                tick   <= 1'b1;
            end else begin
                cuenta <= cuenta + 1'b1;
                tick   <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/divisor_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// divisor_ctrl : run/stop/drain sequencing and divide-ratio load handshake
// Rev 1.0
// ----------------------------------------------------------------------------
module divisor_ctrl
    import divisor_pkg::*;
#(
    parameter int WIDTH       = 22,
    parameter int DEFAULT_DIV = BOARD_DEFAULT_DIV,
    parameter int MIN_DIV     = BOARD_MIN_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] div_value,
    input  logic             div_load,
    output logic             div_ack,
    output logic             cfg_err,
    output logic             busy,
    output logic             s_clk,
    output logic             tick
);

    localparam logic [WIDTH-1:0] DEF_VAL = DEFAULT_DIV[WIDTH-1:0];
    localparam logic [WIDTH-1:0] MIN_VAL = MIN_DIV[WIDTH-1:0];

    state_t           state;
    state_t           next_state;
    logic             count_en;
    logic             clear;
    logic             tc;
    logic             tc_evt;
    logic [WIDTH-1:0] term_reg;
    logic [WIDTH-1:0] pend_reg;
    logic             load_ok;
    logic             load_bad;
    logic             apply;

    divisor_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .count_en (count_en),
        .clear    (clear),
        .term     (term_reg),
        .tc       (tc),
        .s_clk    (s_clk),
        .tick     (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Stopping with s_clk low is immediate; with s_clk high the half-period
    // is drained so consumers never see a runt high pulse.
    always_comb begin
        next_state = state;
        count_en   = 1'b0;
        clear      = 1'b0;
        case (state)
            ST_IDLE: begin
                clear = 1'b1;
                if (enable) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (enable) begin
                    count_en = 1'b1;
                end else if (!s_clk) begin
                    clear      = 1'b1;
                    next_state = ST_IDLE;
                end else begin
                    count_en   = 1'b1;
                    next_state = tc ? ST_IDLE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                count_en = 1'b1;
                if (enable) begin
                    next_state = ST_RUN;
                end else if (tc) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                clear      = 1'b1;
                next_state = ST_IDLE;
            end
        endcase
    end

    assign tc_evt   = count_en & tc;
    assign load_bad = div_load & ((div_value < MIN_VAL) | busy);
    assign load_ok  = div_load & ~busy & (div_value >= MIN_VAL);
    // busy is registered, so a load landing on a TC waits for the next one.
    assign apply    = busy & ((state == ST_IDLE) | tc_evt);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            term_reg <= DEF_VAL;
            pend_reg <= '0;
            busy     <= 1'b0;
            div_ack  <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_err <= load_bad;
            div_ack <= apply;
            if (load_ok) begin
                pend_reg <= div_value;
                busy     <= 1'b1;
            end else if (apply) begin
                term_reg <= pend_reg;
                busy     <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_divisor_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_divisor_ctrl : directed bench for divisor_ctrl (WIDTH=8, DEFAULT_DIV=3)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_divisor_ctrl;

    localparam int WIDTH = 8;

    logic             clk       = 1'b0;
    logic             reset     = 1'b0;
    logic             enable    = 1'b0;
    logic             div_load  = 1'b0;
    logic [WIDTH-1:0] div_value = '0;
    logic             div_ack;
    logic             cfg_err;
    logic             busy;
    logic             s_clk;
    logic             tick;

    int checks = 0;
    int errors = 0;
    int n;
    int acks = 0;
    int acks_before;

    divisor_ctrl #(
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (3),
        .MIN_DIV     (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .div_value (div_value),
        .div_load  (div_load),
        .div_ack   (div_ack),
        .cfg_err   (cfg_err),
        .busy      (busy),
        .s_clk     (s_clk),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset && div_ack) acks++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Edges until tick is seen, capped at limit.
    task automatic until_tick(input int limit, output int cnt);
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (tick !== 1'b1 && cnt < limit);
    endtask

    initial begin
        step(2);
        check("rst_s_clk",   s_clk,   0);
        check("rst_tick",    tick,    0);
        check("rst_div_ack", div_ack, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_busy",    busy,    0);

        // Basic run: first rise 4 cycles into RUN, then every 4 cycles.
        reset  = 1'b1;
        enable = 1'b1;
        until_tick(20, n); check("first_half", n, 5); check("first_rise", s_clk, 1);
        step(1);           check("tick_width", tick, 0);
        until_tick(20, n); check("half_fall", n, 3); check("half_fall_lvl", s_clk, 0);
        until_tick(20, n); check("half_rise", n, 4); check("half_rise_lvl", s_clk, 1);

        // Drain with s_clk high.
        step(1);
        enable = 1'b0;
        until_tick(20, n); check("drain_len", n, 3); check("drain_fall", s_clk, 0);
        until_tick(8, n);  check("idle_no_tick", tick, 0); check("idle_s_clk", s_clk, 0);

        // Load 5 mid-half while running.
        enable = 1'b1;
        until_tick(20, n); check("restart_half", n, 5);
        step(1);
        div_value = 8'd5; div_load = 1'b1;
        step(1);
        div_load = 1'b0;
        check("busy_set", busy, 1);
        until_tick(20, n); check("old_half", n, 2); check("ack_at_tc", div_ack, 1);
        check("busy_clr", busy, 0);
        step(1);           check("ack_width", div_ack, 0);
        until_tick(20, n); check("new_half_a", n, 5);
        until_tick(20, n); check("new_half_b", n, 6);

        // Illegal value rejected.
        div_value = 8'd0; div_load = 1'b1;
        step(1);
        div_load = 1'b0;
        check("cfg_err_zero", cfg_err, 1); check("busy_after_bad", busy, 0);
        step(1);           check("cfg_err_width", cfg_err, 0);
        until_tick(20, n); check("period_kept", n, 4);

        // Second load while busy rejected; first value wins.
        div_value = 8'd2; div_load = 1'b1;
        step(1);
        div_value = 8'd7;
        step(1);
        div_load = 1'b0;
        check("cfg_err_busy", cfg_err, 1); check("busy_kept", busy, 1);
        until_tick(20, n); check("pend_old_half", n, 4); check("ack_first", div_ack, 1);
        until_tick(20, n); check("first_value_applied", n, 3);

        // Load coincident with TC waits for the following TC.
        step(2);
        div_value = 8'd4; div_load = 1'b1;
        until_tick(20, n);
        div_load = 1'b0;
        check("coinc_tc", n, 1); check("coinc_busy", busy, 1); check("coinc_no_ack", div_ack, 0);
        until_tick(20, n); check("coinc_hold_half", n, 3); check("coinc_ack", div_ack, 1);
        until_tick(20, n); check("coinc_new_half", n, 5);

        // Reset mid-half with a pending load.
        div_value = 8'd6; div_load = 1'b1;
        step(1);
        div_load = 1'b0;
        check("busy_before_rst", busy, 1);
        acks_before = acks;
        step(1);
        reset = 1'b0;
        #1;
        check("rst_mid_s_clk", s_clk,   0);
        check("rst_mid_busy",  busy,    0);
        check("rst_mid_tick",  tick,    0);
        check("rst_mid_ack",   div_ack, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        until_tick(20, n); check("post_rst_first", n, 5);
        until_tick(20, n); check("post_rst_half", n, 4);
        check("post_rst_no_ack", acks, acks_before);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
